// File: rtl/ts3d_gb_pkg.sv
// ----------------------------------------------------------------------------
// Module  : ts3d_gb_pkg
// Purpose : Shared constants and types for the global-buffer banks.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ts3d_gb_pkg;

  localparam int unsigned PSUM_WIDTH_DEFAULT = 24;
  localparam int unsigned NUM_PSUM_LANE      = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } psum_gb_state_e;

endpackage

`default_nettype wire

// File: rtl/psum_gb_bank_if.sv
// ----------------------------------------------------------------------------
// Module  : psum_gb_bank_if
// Purpose : PEB read/write and output-path handshakes of one psum bank.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface psum_gb_bank_if
  import ts3d_gb_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEFAULT
);

  logic                  GBPSUM_val;
  logic [PSUM_WIDTH-1:0] GBPSUM_data;
  logic                  PSUMGB_rdy;
  logic                  PSUMGB_val;
  logic [PSUM_WIDTH-1:0] PSUMGB_data;
  logic                  GBPSUM_rdy;
  logic                  OUT_val;
  logic [PSUM_WIDTH-1:0] OUT_data;
  logic                  OUT_rdy;

  // master is the bank, slave is the PEB / output-path side
  modport master (
    output GBPSUM_val, GBPSUM_data, GBPSUM_rdy, OUT_val, OUT_data,
    input  PSUMGB_rdy, PSUMGB_val, PSUMGB_data, OUT_rdy
  );

  modport slave (
    input  GBPSUM_val, GBPSUM_data, GBPSUM_rdy, OUT_val, OUT_data,
    output PSUMGB_rdy, PSUMGB_val, PSUMGB_data, OUT_rdy
  );

endinterface

`default_nettype wire

// File: rtl/psum_ring_fifo.sv
// ----------------------------------------------------------------------------
// Module  : psum_ring_fifo
// Purpose : Ring-buffer psum storage with pointers that persist across passes.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module psum_ring_fifo
  import ts3d_gb_pkg::*;
#(
  parameter int WIDTH = PSUM_WIDTH_DEFAULT,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Full/empty reflect the registered count only, so there is no bypass.
  assign o_full    = (r_count == c_cnt_w'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/psum_gb_bank.sv
// ----------------------------------------------------------------------------
// Module  : psum_gb_bank
// Purpose : Psum global-buffer bank for one PEB lane with first/last-pass steering.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module psum_gb_bank
  import ts3d_gb_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEFAULT,
  parameter int DEPTH      = 64,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 next_block,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_first,
  input  logic                 cfg_last,
  psum_gb_bank_if.master       bus,
  output logic                 blk_done,
  output logic                 busy
);

  psum_gb_state_e        r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_rd_cnt;
  logic [LEN_WIDTH-1:0]  r_wr_cnt;
  logic                  r_first;
  logic                  r_last;

  logic                  w_run;
  logic                  w_rd_active;
  logic                  w_wr_active;
  logic                  w_rd_hs;
  logic                  w_wr_hs;
  logic                  w_wr_done;
  logic                  w_full;
  logic                  w_empty;
  logic [PSUM_WIDTH-1:0] w_fifo_rdata;

  assign w_run       = (r_state == RUN);
  assign w_rd_active = w_run && (r_rd_cnt < r_len);
  assign w_wr_active = w_run && (r_wr_cnt < r_len);
  assign w_rd_hs     = bus.GBPSUM_val & bus.PSUMGB_rdy;
  assign w_wr_hs     = bus.PSUMGB_val & bus.GBPSUM_rdy;
  assign w_wr_done   = w_wr_hs && ((r_wr_cnt + LEN_WIDTH'(1)) == r_len);
  assign blk_done    = w_wr_done;
  assign busy        = w_run;

  // First pass serves zeros without touching the FIFO.
  always_comb begin
    bus.GBPSUM_val  = 1'b0;
    bus.GBPSUM_data = '0;
    if (w_rd_active) begin
      if (r_first) begin
        bus.GBPSUM_val = 1'b1;
      end else begin
        bus.GBPSUM_val  = ~w_empty;
        bus.GBPSUM_data = w_empty ? '0 : w_fifo_rdata;
      end
    end
  end

  // Last pass forwards straight to the output path instead of storing.
  always_comb begin
    bus.GBPSUM_rdy = 1'b0;
    bus.OUT_val    = 1'b0;
    bus.OUT_data   = '0;
    if (w_wr_active) begin
      if (r_last) begin
        bus.OUT_val    = bus.PSUMGB_val;
        bus.OUT_data   = bus.PSUMGB_data;
        bus.GBPSUM_rdy = bus.OUT_rdy;
      end else begin
        bus.GBPSUM_rdy = ~w_full;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (next_block) begin
            r_state  <= RUN;
            r_len    <= cfg_len;
            r_first  <= cfg_first;
            r_last   <= cfg_last;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
          end
        end
        RUN: begin
          if (w_rd_hs) begin
            r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
          end
          if (w_wr_hs) begin
            r_wr_cnt <= r_wr_cnt + LEN_WIDTH'(1);
          end
          if (w_wr_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  psum_ring_fifo #(
    .WIDTH (PSUM_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_wr_hs & ~r_last),
    .i_push_data (bus.PSUMGB_data),
    .i_pop       (w_rd_hs & ~r_first),
    .o_rd_data   (w_fifo_rdata),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_psum_gb_bank.sv
// ----------------------------------------------------------------------------
// Module  : tb_psum_gb_bank
// Purpose : Scoreboard bench for the psum global-buffer bank.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_psum_gb_bank;
  import ts3d_gb_pkg::*;

  localparam int PW    = 24;
  localparam int DEPTH = 64;
  localparam int LW    = 7;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          next_block = 1'b0;
  logic [LW-1:0] cfg_len    = '0;
  logic          cfg_first  = 1'b0;
  logic          cfg_last   = 1'b0;
  logic          blk_done;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW-1:0] sb_q [$];

  psum_gb_bank_if #(.PSUM_WIDTH(PW)) bus ();

  psum_gb_bank #(
    .PSUM_WIDTH (PW),
    .DEPTH      (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_block (next_block),
    .cfg_len    (cfg_len),
    .cfg_first  (cfg_first),
    .cfg_last   (cfg_last),
    .bus        (bus),
    .blk_done   (blk_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic start_pass(input int len, input bit first, input bit last);
    @(posedge clk); #1;
    next_block = 1'b1;
    cfg_len    = LW'(len);
    cfg_first  = first;
    cfg_last   = last;
    @(posedge clk); #1;
    next_block = 1'b0;
    cfg_len    = '0;
    cfg_first  = 1'b0;
    cfg_last   = 1'b0;
  endtask

  task automatic test_reset;
    bus.PSUMGB_val  = 1'b0;
    bus.PSUMGB_data = '0;
    bus.PSUMGB_rdy  = 1'b0;
    bus.OUT_rdy     = 1'b0;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (busy !== 1'b0 || blk_done !== 1'b0 || bus.GBPSUM_val !== 1'b0 || bus.GBPSUM_data !== '0 ||
        bus.GBPSUM_rdy !== 1'b0 || bus.OUT_val !== 1'b0 || bus.OUT_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b gval=%b gdata=%0h grdy=%b oval=%b odata=%0h, want all 0",
               busy, blk_done, bus.GBPSUM_val, bus.GBPSUM_data, bus.GBPSUM_rdy, bus.OUT_val, bus.OUT_data);
    end
    n_tests++;
    if (dut.u_fifo.r_count !== 0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", dut.u_fifo.r_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || bus.GBPSUM_val !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b gval=%b want 0 0", busy, bus.GBPSUM_val);
    end
  endtask

  // One full pass: reads and writes run concurrently, checked against the scoreboard.
  task automatic test_pass(input string name, input int len, input bit first, input bit last,
                           input int base, input int step, input int hold, input bit toggle);
    int            rd_left;
    int            wr_left;
    int            cyc;
    bit            rd_hs;
    bit            wr_hs;
    bit            exp_val;
    bit            exp_rdy;
    bit            exp_done;
    bit            out_rdy_v;
    logic [PW-1:0] exp_data;
    logic [PW-1:0] wdata;
    start_pass(len, first, last);
    rd_left   = len;
    wr_left   = len;
    cyc       = 0;
    wdata     = PW'(base);
    out_rdy_v = last;
    bus.PSUMGB_val  = 1'b1;
    bus.PSUMGB_data = wdata;
    bus.PSUMGB_rdy  = (hold == 0);
    bus.OUT_rdy     = out_rdy_v;
    while (wr_left > 0 && cyc < 4 * len + 20) begin
      @(negedge clk);
      rd_hs = 1'b0;
      n_tests++;
      if (dut.u_fifo.r_count !== sb_q.size()) begin
        n_fail++;
        $display("FAIL %s count cyc=%0d: got %0d want %0d", name, cyc, dut.u_fifo.r_count, sb_q.size());
      end
      exp_val = (rd_left > 0) && (first || sb_q.size() != 0);
      n_tests++;
      if (bus.GBPSUM_val !== exp_val) begin
        n_fail++;
        $display("FAIL %s rd_val cyc=%0d: got %b want %b", name, cyc, bus.GBPSUM_val, exp_val);
      end
      if (exp_val) begin
        exp_data = first ? '0 : sb_q[0];
        n_tests++;
        if (bus.GBPSUM_data !== exp_data) begin
          n_fail++;
          $display("FAIL %s rd_data cyc=%0d: got %0d want %0d", name, cyc, bus.GBPSUM_data, exp_data);
        end
        rd_hs = bus.PSUMGB_rdy;
      end
      if (last) begin
        exp_rdy = out_rdy_v;
        n_tests++;
        if (bus.OUT_val !== 1'b1 || bus.OUT_data !== wdata) begin
          n_fail++;
          $display("FAIL %s out cyc=%0d: got val=%b data=%0d want val=1 data=%0d",
                   name, cyc, bus.OUT_val, bus.OUT_data, wdata);
        end
      end else begin
        exp_rdy = (sb_q.size() != DEPTH);
        n_tests++;
        if (bus.OUT_val !== 1'b0) begin
          n_fail++;
          $display("FAIL %s out_val cyc=%0d: got %b want 0", name, cyc, bus.OUT_val);
        end
      end
      n_tests++;
      if (bus.GBPSUM_rdy !== exp_rdy) begin
        n_fail++;
        $display("FAIL %s wr_rdy cyc=%0d: got %b want %b", name, cyc, bus.GBPSUM_rdy, exp_rdy);
      end
      wr_hs    = exp_rdy;
      exp_done = wr_hs && (wr_left == 1);
      n_tests++;
      if (blk_done !== exp_done) begin
        n_fail++;
        $display("FAIL %s blk_done cyc=%0d: got %b want %b", name, cyc, blk_done, exp_done);
      end
      if (rd_hs) begin
        rd_left--;
        if (!first) void'(sb_q.pop_front());
      end
      if (wr_hs) begin
        wr_left--;
        if (!last) sb_q.push_back(wdata);
      end
      @(posedge clk); #1;
      cyc++;
      if (wr_hs) wdata = wdata + PW'(step);
      bus.PSUMGB_data = wdata;
      bus.PSUMGB_rdy  = (cyc >= hold);
      out_rdy_v       = last && !(toggle && (cyc % 3 == 1));
      bus.OUT_rdy     = out_rdy_v;
    end
    n_tests++;
    if (wr_left != 0) begin
      n_fail++;
      $display("FAIL %s timeout: writes left %0d want 0", name, wr_left);
    end
    bus.PSUMGB_val = 1'b0;
    bus.PSUMGB_rdy = 1'b0;
    bus.OUT_rdy    = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || bus.GBPSUM_val !== 1'b0 || bus.GBPSUM_rdy !== 1'b0 ||
        dut.u_fifo.r_count !== sb_q.size()) begin
      n_fail++;
      $display("FAIL %s end_state: got busy=%b gval=%b grdy=%b count=%0d want 0 0 0 %0d",
               name, busy, bus.GBPSUM_val, bus.GBPSUM_rdy, dut.u_fifo.r_count, sb_q.size());
    end
  endtask

  task automatic test_first_middle_last;
    test_pass("first",  4, 1'b1, 1'b0, 10,  10, 0, 1'b0);
    test_pass("middle", 4, 1'b0, 1'b0, 11,  10, 0, 1'b0);
    test_pass("last",   4, 1'b0, 1'b1, 100, 1,  0, 1'b1);
  endtask

  task automatic test_full_empty;
    test_pass("fill",       64, 1'b1, 1'b0, 1000, 1, 0, 1'b0);
    test_pass("full_hold",  64, 1'b0, 1'b0, 2000, 1, 2, 1'b0);
    test_pass("drain",      64, 1'b0, 1'b1, 3000, 1, 0, 1'b0);
    test_pass("empty_nobp", 2,  1'b0, 1'b0, 7,    1, 0, 1'b0);
  endtask

  task automatic test_wrap;
    test_pass("wrap_first", 48, 1'b1, 1'b0, 4000, 3, 0, 1'b0);
    test_pass("wrap_mid1",  48, 1'b0, 1'b0, 5000, 3, 0, 1'b0);
    test_pass("wrap_mid2",  48, 1'b0, 1'b0, 6000, 3, 0, 1'b0);
    test_pass("wrap_last",  48, 1'b0, 1'b1, 7000, 3, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run;
    start_pass(8, 1'b0, 1'b0);
    bus.PSUMGB_val  = 1'b1;
    bus.PSUMGB_data = PW'(555);
    bus.PSUMGB_rdy  = 1'b1;
    @(posedge clk); #3;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || blk_done !== 1'b0 || bus.GBPSUM_val !== 1'b0 || bus.GBPSUM_data !== '0 ||
        bus.GBPSUM_rdy !== 1'b0 || bus.OUT_val !== 1'b0 || bus.OUT_data !== '0 ||
        dut.u_fifo.r_count !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b gval=%b grdy=%b oval=%b count=%0d want all 0",
               busy, bus.GBPSUM_val, bus.GBPSUM_rdy, bus.OUT_val, dut.u_fifo.r_count);
    end
    sb_q.delete();
    bus.PSUMGB_val = 1'b0;
    bus.PSUMGB_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    test_pass("restart_first", 3, 1'b1, 1'b0, 70, 1, 0, 1'b0);
    test_pass("restart_read",  3, 1'b0, 1'b0, 80, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_middle_last();
    test_full_empty();
    test_wrap();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
